multiplier_seq: RTL and testbench
=================================

MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

Interface
REQ-001 SHALL declare parameter C_NUM_BITS, default 4, giving the operand width N (N >= 2).
REQ-002 SHALL have port CK, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port R, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port E, input, 1 bit: clock enable; when 0, all state is frozen.
REQ-005 SHALL have port START, input, 1 bit: request to begin a multiply.
REQ-006 SHALL have port A, input, N bits: multiplicand, unsigned.
REQ-007 SHALL have port B, input, N bits: multiplier, unsigned.
REQ-008 SHALL have port P, output, 2N bits: product register.
REQ-009 SHALL have port BUSY, output, 1 bit: high while a multiply is in progress.
REQ-010 SHALL have port DONE, output, 1 bit: one-cycle pulse marking that P is updated.

Function
REQ-011 SHALL implement a three-state FSM with states IDLE, RUN and FIN.
REQ-012 SHALL treat the "START sample edge" as a rising CK edge with E=1 and START=1 while in IDLE or FIN.
REQ-013 SHALL, at the START sample edge, capture A into MCAND, load ACC (N+1 bits) to 0, load MQ to B, clear the step counter, and enter RUN.
REQ-014 SHALL, on each E=1 edge in RUN:
- if MQ[0]=1, form ACC_n = {0, ACC[N-1:0]} + {0, MCAND}, else ACC_n = ACC;
- shift {ACC_n, MQ} right one bit, with 0 entering the MSB;
- increment the step counter.
REQ-015 SHALL leave RUN on the edge performing step N, enter FIN, and write P = {ACC[N-1:0], MQ} using the post-shift values.
REQ-016 SHALL assert DONE for exactly the one cycle spent in FIN.
REQ-017 SHALL leave FIN on the next E=1 edge, going to RUN if START=1 (back-to-back operation), else to IDLE.
REQ-018 SHALL make latency exactly N+1 enabled edges from the START sample edge to the first cycle with DONE=1.
REQ-019 SHALL drive BUSY=1 exactly while in RUN.
REQ-020 SHALL ignore START while in RUN, with no effect on operands or count.
REQ-021 SHALL hold P stable from one FIN write to the next; P changes at no other time except reset.
REQ-022 SHALL, when E=0, hold all state, including FIN; DONE therefore stays high until the next E=1 edge, and latency extends by the number of E=0 cycles.
REQ-023 SHALL produce the full 2N-bit product with no overflow, because ACC carries one guard bit.
REQ-024 SHALL use a step counter of width clog2(N)+1 that does not wrap within one operation.

Reset
REQ-025 SHALL, on a rising CK edge with R=1 and regardless of E, enter IDLE and clear P, ACC, MQ, MCAND and the counter to 0.
REQ-026 SHALL drive BUSY=0 and DONE=0 in the cycle after a reset edge.
REQ-027 SHALL abort an in-progress operation on reset without producing DONE.
REQ-028 SHALL give R priority over START and E at the same edge.

Structure
REQ-029 SHALL take the state enum (IDLE, RUN, FIN) and the default C_NUM_BITS from a shared package, multiplier_pkg.
REQ-030 SHALL place the datapath (ACC/MQ/MCAND registers and the N+1-bit adder) in one sub-module, multiplier_datapath, while the FSM and counter live in multiplier_seq.

Verification
REQ-031 SHALL cover: N=4, A=3, B=5, START for one cycle, E=1 -> DONE in cycle 5 after the sample edge, P=0x0F, BUSY high for cycles 1-4.
REQ-032 SHALL cover: A=15, B=15 -> P=0xE1 (225); then A=0, B=9 -> P=0x00.
REQ-033 SHALL cover: START held high continuously with A=2, B=7, then A=4, B=4 applied in FIN -> DONE pulses 5 cycles apart, P=0x0E then P=0x10.
REQ-034 SHALL cover: START asserted again at RUN cycle 2 with different A and B -> ignored; P equals the product of the original operands.
REQ-035 SHALL cover: R=1 at RUN cycle 2 -> BUSY=0, P=0 on the next cycle, no DONE pulse; a following START with A=6, B=6 -> P=0x24.
REQ-036 SHALL cover: E=0 for 3 cycles during RUN with A=9, B=11 -> DONE after 8 cycles, P=0x63.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package multiplier_pkg;

    localparam int unsigned DefaultNumBits = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

endpackage

// File: rtl/multiplier_datapath.sv
// Shift-and-add datapath: MCAND, ACC (with guard bit) and MQ registers plus the adder.
module multiplier_datapath
    import multiplier_pkg::*;
#(
    parameter int unsigned NumBits = DefaultNumBits
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic                   step_i,
    input  logic [NumBits-1:0]     mcand_i,
    input  logic [NumBits-1:0]     mplier_i,
    output logic [2*NumBits-1:0]   prod_next_o
);

    logic [NumBits:0]   acc_q, acc_d;
    logic [NumBits-1:0] mq_q, mq_d;
    logic [NumBits-1:0] mcand_q, mcand_d;

    logic [NumBits:0]   sum;
    logic [NumBits-1:0] acc_shift;
    logic [NumBits-1:0] mq_shift;

    always_comb begin
        sum = mq_q[0] ? ({1'b0, acc_q[NumBits-1:0]} + {1'b0, mcand_q}) : acc_q;
        // {sum, mq} shifted right; a zero enters above the guard bit
        acc_shift = sum[NumBits:1];
        mq_shift  = {sum[0], mq_q[NumBits-1:1]};
        prod_next_o = {acc_shift, mq_shift};

        acc_d   = acc_q;
        mq_d    = mq_q;
        mcand_d = mcand_q;
        if (load_i) begin
            acc_d   = '0;
            mq_d    = mplier_i;
            mcand_d = mcand_i;
        end else if (step_i) begin
            acc_d = {1'b0, acc_shift};
            mq_d  = mq_shift;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q   <= '0;
            mq_q    <= '0;
            mcand_q <= '0;
        end else begin
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            mcand_q <= mcand_d;
        end
    end

endmodule

// File: rtl/multiplier_seq.sv
// Sequential unsigned multiplier: control FSM, step counter and product register.
module multiplier_seq
    import multiplier_pkg::*;
#(
    parameter int unsigned C_NUM_BITS = DefaultNumBits
) (
    input  logic                      CK,
    input  logic                      R,
    input  logic                      E,
    input  logic                      START,
    input  logic [C_NUM_BITS-1:0]     A,
    input  logic [C_NUM_BITS-1:0]     B,
    output logic [2*C_NUM_BITS-1:0]   P,
    output logic                      BUSY,
    output logic                      DONE
);

    localparam int unsigned CntW = $clog2(C_NUM_BITS) + 1;
    localparam logic [CntW-1:0] LastStep = CntW'(C_NUM_BITS - 1);

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [2*C_NUM_BITS-1:0]   p_q, p_d;
    logic [2*C_NUM_BITS-1:0]   prod_next;
    logic                      load;
    logic                      step;

    multiplier_datapath #(
        .NumBits (C_NUM_BITS)
    ) u_datapath (
        .clk_i       (CK),
        .rst_i       (R),
        .load_i      (load),
        .step_i      (step),
        .mcand_i     (A),
        .mplier_i    (B),
        .prod_next_o (prod_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        load    = 1'b0;
        step    = 1'b0;
        if (E) begin
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == LastStep) begin
                        p_d     = prod_next;
                        state_d = StFin;
                    end
                end
                StFin: begin
                    // START here is a new sample edge, giving back-to-back operation
                    if (START) begin
                        load    = 1'b1;
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (R) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign P    = p_q;
    assign BUSY = (state_q == StRun);
    assign DONE = (state_q == StFin);

endmodule

// File: tb/tb_multiplier_seq.sv
// Randomized scoreboard bench for multiplier_seq with directed corner cases.
module tb_multiplier_seq;

    localparam int N = 4;

    logic           CK = 1'b0;
    logic           R = 1'b1;
    logic           E = 1'b0;
    logic           START = 1'b0;
    logic [N-1:0]   A = '0;
    logic [N-1:0]   B = '0;
    logic [2*N-1:0] P;
    logic           BUSY;
    logic           DONE;

    typedef struct {
        logic [2*N-1:0] prod;
        int             cyc;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    int             total = 0;
    int             bad = 0;
    int             cyc = 0;
    logic           r_last = 1'b0;
    logic           done_prev = 1'b0;
    logic [2*N-1:0] p_prev = '0;

    multiplier_seq #(
        .C_NUM_BITS (N)
    ) dut (
        .CK    (CK),
        .R     (R),
        .E     (E),
        .START (START),
        .A     (A),
        .B     (B),
        .P     (P),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CK = ~CK;

    always @(posedge CK) begin
        cyc    <= cyc + 1;
        r_last <= R;
    end

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        int p;
        p = int'(a) * int'(b);
        return p[2*N-1:0];
    endfunction

    task automatic tick(input bit r, input bit e, input bit st,
                        input logic [N-1:0] a, input logic [N-1:0] b);
        R = r;
        E = e;
        START = st;
        A = a;
        B = b;
        @(posedge CK);
        #1;
    endtask

    // One multiply from IDLE or FIN; leaves the DUT in FIN.
    task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, input bit run_start,
                      input logic [N-1:0] ra, input logic [N-1:0] rb,
                      input int stalls, input int stall_pos);
        tick(0, 1, 1, a, b);
        sb.push_back('{prod: model(a, b), cyc: cyc + N + stalls});
        for (int i = 0; i < N; i++) begin
            if (i == stall_pos) begin
                for (int j = 0; j < stalls; j++) begin
                    tick(0, 0, 1'($urandom), ra, rb);
                    chk("busy_stall", BUSY, 1);
                end
            end
            tick(0, 1, run_start, ra, rb);
            if (i < N - 1) begin
                chk("busy_run", BUSY, 1);
                chk("done_run", DONE, 0);
            end else begin
                chk("busy_fin", BUSY, 0);
            end
        end
    endtask

    // Monitor: pops the scoreboard once per FIN visit and polices P stability.
    always @(negedge CK) begin
        if (r_last) begin
            chk("reset_p", P, 0);
            chk("reset_done", DONE, 0);
        end else if (DONE && !done_prev) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got DONE=1 P=%0d, required no pending result", P);
            end else begin
                mon_e = sb.pop_front();
                chk("product", P, mon_e.prod);
                chk("done_cycle", cyc, mon_e.cyc);
            end
        end else begin
            chk("p_hold", P, p_prev);
        end
        done_prev = DONE;
        p_prev    = P;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required completion within bound");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] ra, rb;
        // Reset wins over START and E
        tick(1, 1, 1, 4'hF, 4'hF);
        tick(1, 1, 1, 4'hF, 4'hF);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_p", P, 0);

        // E=0 freezes IDLE even with START
        tick(0, 0, 1, 3, 5);
        chk("idle_e0_busy", BUSY, 0);

        op(3, 5, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        chk("idle_done", DONE, 0);
        chk("idle_busy", BUSY, 0);

        op(15, 15, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);
        op(0, 9, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);

        // START held high: back-to-back operations
        op(2, 7, 1, 2, 7, 0, 0);
        op(4, 4, 1, 4, 4, 0, 0);
        tick(0, 1, 0, 0, 0);

        // START during RUN with different operands is ignored
        op(5, 3, 1, 12, 13, 0, 0);
        tick(0, 1, 0, 0, 0);

        // Reset in RUN cycle 2 aborts with no DONE
        tick(0, 1, 1, 5, 3);
        tick(0, 1, 0, 0, 0);
        tick(1, 1, 1, 9, 9);
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        chk("abort_p", P, 0);
        tick(0, 1, 0, 0, 0);
        op(6, 6, 0, 0, 0, 0, 0);
        tick(0, 1, 0, 0, 0);

        // Three disabled cycles mid-RUN stretch latency
        op(9, 11, 0, 0, 0, 3, 2);
        tick(0, 1, 0, 0, 0);

        // DONE holds through E=0 in FIN
        op(7, 13, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        chk("fin_hold_done", DONE, 1);
        tick(0, 0, 0, 0, 0);
        chk("fin_hold_done", DONE, 1);
        tick(0, 1, 0, 0, 0);
        chk("fin_exit_done", DONE, 0);

        for (int k = 0; k < 40; k++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            op(N'($urandom), N'($urandom), 1'($urandom), ra, rb,
               $urandom_range(0, 3), $urandom_range(0, N - 1));
            if ($urandom_range(0, 1) == 0) begin
                tick(0, 1, 0, 0, 0);
                repeat ($urandom_range(0, 2)) tick(0, 1, 0, 0, 0);
            end
        end
        tick(0, 1, 0, 0, 0);

        repeat (3) tick(0, 1, 0, 0, 0);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
